// File: rtl/stream_fifo_param.sv
// Parametrised valid/ready stream FIFO with occupancy/free-space reporting and almost flags.
// Optional peak-occupancy watermark is built when STREAM_FIFO_WATERMARK_EN is defined.
module stream_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int AF_LEVEL   = (1 << DEPTH_LOG2) - 2,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [DATA_WIDTH-1:0] push_payload,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [DATA_WIDTH-1:0] pop_payload,
    input  logic                  flush,
    output logic [DEPTH_LOG2:0]   occupancy,
    output logic [DEPTH_LOG2:0]   availability,
    output logic                  almost_full,
    output logic                  almost_empty,
    input  logic                  wm_clear,
    output logic [DEPTH_LOG2:0]   wm_peak
);

    localparam int                   DEPTH    = 1 << DEPTH_LOG2;
    localparam int                   CW       = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]        DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]        AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0]        AE_C     = CW'(AE_LEVEL);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [DEPTH_LOG2-1:0] r_push_ptr;
    logic [DEPTH_LOG2-1:0] r_pop_ptr;
    logic                  r_rising;
    logic                  r_hz;

    logic                  w_match;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pushing;
    logic                  w_popping;
    logic [DEPTH_LOG2-1:0] w_pop_ptr_next;

    assign w_match   = (r_push_ptr == r_pop_ptr);
    assign w_full    = w_match & r_rising;
    assign w_empty   = w_match & ~r_rising;

    assign push_ready = ~w_full;
    // r_hz flags a read that raced the same-edge write to that slot; stale data must not be shown.
    assign pop_valid  = ~w_empty & ~(r_hz & ~w_full);

    assign w_pushing = push_valid & push_ready;
    assign w_popping = pop_valid & pop_ready;

    assign w_pop_ptr_next = flush     ? '0 :
                            w_popping ? r_pop_ptr + PTR_ONE :
                                        r_pop_ptr;

    assign occupancy    = {w_full, r_push_ptr - r_pop_ptr};
    assign availability = DEPTH_C - occupancy;
    assign almost_full  = (occupancy >= AF_C);
    assign almost_empty = (occupancy <= AE_C);
    assign pop_payload  = r_rd_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_push_ptr <= '0;
            r_pop_ptr  <= '0;
            r_rising   <= 1'b0;
            r_hz       <= 1'b0;
        end else begin
            if (flush) begin
                r_push_ptr <= '0;
                r_pop_ptr  <= '0;
                r_rising   <= 1'b0;
            end else begin
                if (w_pushing) begin
                    r_push_ptr <= r_push_ptr + PTR_ONE;
                end
                if (w_popping) begin
                    r_pop_ptr <= w_pop_ptr_next;
                end
                if (w_pushing != w_popping) begin
                    r_rising <= w_pushing;
                end
            end
            r_hz <= (w_pop_ptr_next == r_push_ptr);
        end
    end

    // Storage stays out of reset so it maps onto block RAM; the read register is the output stage.
    always_ff @(posedge clk) begin
        if (w_pushing) begin
            r_mem[r_push_ptr] <= push_payload;
        end
        r_rd_data <= r_mem[w_pop_ptr_next];
    end

`ifdef STREAM_FIFO_WATERMARK_EN
    logic [CW-1:0] r_wm_peak;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wm_peak <= '0;
        end else if (wm_clear) begin
            r_wm_peak <= occupancy;
        end else if (occupancy > r_wm_peak) begin
            r_wm_peak <= occupancy;
        end
    end

    assign wm_peak = r_wm_peak;
`else
    logic w_unused_wm_clear;

    assign w_unused_wm_clear = wm_clear;
    assign wm_peak           = '0;
`endif

endmodule

// File: tb/tb_stream_fifo_param.sv
// Scoreboard bench for stream_fifo_param: the driver queues expected words, a negedge monitor
// checks every pop handshake; directed checks cover flags, full/empty, flush, reset and watermark.
module tb_stream_fifo_param;

`ifdef STREAM_FIFO_WATERMARK_EN
    localparam bit WM = 1'b1;
`else
    localparam bit WM = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       push_valid;
    logic       push_ready;
    logic [7:0] push_payload;
    logic       pop_valid;
    logic       pop_ready;
    logic [7:0] pop_payload;
    logic       flush;
    logic [4:0] occupancy;
    logic [4:0] availability;
    logic       almost_full;
    logic       almost_empty;
    logic       wm_clear;
    logic [4:0] wm_peak;

    int         checks;
    int         errors;
    logic [7:0] exp_q[$];

    stream_fifo_param #(
        .DATA_WIDTH(8),
        .DEPTH_LOG2(4),
        .AF_LEVEL  (14),
        .AE_LEVEL  (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .push_valid  (push_valid),
        .push_ready  (push_ready),
        .push_payload(push_payload),
        .pop_valid   (pop_valid),
        .pop_ready   (pop_ready),
        .pop_payload (pop_payload),
        .flush       (flush),
        .occupancy   (occupancy),
        .availability(availability),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .wm_clear    (wm_clear),
        .wm_peak     (wm_peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: a pop completes at the next rising edge whenever valid and ready are both high now.
    always @(negedge clk) begin
        if (!reset && pop_valid && pop_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: actual 0x%0h required none", pop_payload);
            end else begin
                logic [7:0] exp_b;
                exp_b = exp_q.pop_front();
                if (pop_payload !== exp_b) begin
                    errors++;
                    $display("FAIL pop_data: actual 0x%0h required 0x%0h", pop_payload, exp_b);
                end else begin
                    $display("pop  0x%0h", pop_payload);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        push_valid   = 1'b1;
        push_payload = d;
        exp_q.push_back(d);
        tick();
        push_valid   = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        pop_ready = 1'b1;
        while (occupancy != 0 && n < 64) begin
            tick();
            n++;
        end
        pop_ready = 1'b0;
        check({name, "_occ"}, int'(occupancy), 0);
        check({name, "_left"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_push_ready"}, int'(push_ready), 1);
        check({p, "_pop_valid"}, int'(pop_valid), 0);
        check({p, "_occ"}, int'(occupancy), 0);
        check({p, "_avail"}, int'(availability), 16);
        check({p, "_af"}, int'(almost_full), 0);
        check({p, "_ae"}, int'(almost_empty), 1);
        check({p, "_wm"}, int'(wm_peak), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        push_valid   = 1'b0;
        push_payload = 8'h00;
        pop_ready    = 1'b0;
        flush        = 1'b0;
        wm_clear     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_reset_vals("rst");

        // Single word: one masked cycle, then visible.
        tick();
        push_word(8'hA5);
        check("one_occ", int'(occupancy), 1);
        check("one_masked", int'(pop_valid), 0);
        check("one_ae", int'(almost_empty), 1);
        tick();
        check("one_valid", int'(pop_valid), 1);
        check("one_data", int'(pop_payload), 8'hA5);
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;
        check("one_after_occ", int'(occupancy), 0);
        check("one_after_ae", int'(almost_empty), 1);
        check("one_after_valid", int'(pop_valid), 0);

        // Fill to full, one pop frees a slot on the next cycle.
        for (int i = 0; i < 16; i++) push_word(8'(i));
        check("full_push_ready", int'(push_ready), 0);
        check("full_occ", int'(occupancy), 16);
        check("full_avail", int'(availability), 0);
        check("full_af", int'(almost_full), 1);
        check("full_valid", int'(pop_valid), 1);
        pop_ready = 1'b1;
        #1;
        check("full_no_passthru", int'(push_ready), 0);
        tick();
        pop_ready = 1'b0;
        check("full_pop_ready_back", int'(push_ready), 1);
        check("full_pop_occ", int'(occupancy), 15);
        check("full_pop_avail", int'(availability), 1);
        drain("full_drain");

        // Streaming: prefill 4, then 40 push+pop cycles with constant occupancy.
        for (int i = 0; i < 4; i++) push_word(8'(8'h20 + i));
        check("stream_pre_occ", int'(occupancy), 4);
        check("stream_pre_ae", int'(almost_empty), 0);
        for (int i = 0; i < 40; i++) begin
            push_valid   = 1'b1;
            push_payload = 8'(8'h40 + i);
            exp_q.push_back(push_payload);
            pop_ready    = 1'b1;
            tick();
            check("stream_occ", int'(occupancy), 4);
        end
        push_valid = 1'b0;
        drain("stream_drain");

        // Flush with a concurrent push: nothing from before, and not 0x77, may appear.
        for (int i = 0; i < 5; i++) push_word(8'(8'h30 + i));
        check("flush_pre_occ", int'(occupancy), 5);
        flush        = 1'b1;
        push_valid   = 1'b1;
        push_payload = 8'h77;
        exp_q.delete();
        tick();
        flush      = 1'b0;
        push_valid = 1'b0;
        check("flush_occ", int'(occupancy), 0);
        check("flush_valid", int'(pop_valid), 0);
        check("flush_avail", int'(availability), 16);
        tick();
        check("flush_still_empty", int'(pop_valid), 0);
        push_word(8'h55);
        tick();
        check("flush_next_valid", int'(pop_valid), 1);
        drain("flush_drain");

        // Watermark: peak was 16 from the fill, then clear and a 12-deep burst.
        check("wm_before_clear", int'(wm_peak), WM ? 16 : 0);
        wm_clear = 1'b1;
        tick();
        wm_clear = 1'b0;
        check("wm_cleared", int'(wm_peak), 0);
        for (int i = 0; i < 12; i++) push_word(8'(8'h60 + i));
        check("wm_occ12", int'(occupancy), 12);
        check("wm_af_below", int'(almost_full), 0);
        drain("wm_drain");
        check("wm_peak12", int'(wm_peak), WM ? 12 : 0);

        // Asynchronous reset mid-cycle with 9 words stored.
        for (int i = 0; i < 9; i++) push_word(8'(8'h80 + i));
        check("arst_pre_occ", int'(occupancy), 9);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_reset_vals("arst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        push_word(8'hC3);
        tick();
        check("arst_resume_valid", int'(pop_valid), 1);
        drain("arst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_fifo_param.md
# stream_fifo_param

Parametrised synchronous stream FIFO, the general-purpose successor to the fixed 8-bit × 16 stream FIFO. It adds configurable width and depth, free-space reporting, almost-full/almost-empty flags and an optional peak-occupancy watermark. It sits between any two valid/ready stream endpoints in one clock domain.

## Interface
- DATA_WIDTH, 8, payload width in bits (≥1)
- DEPTH_LOG2, 4, log2 of entry count; DEPTH = 2^DEPTH_LOG2 (DEPTH_LOG2 ≥ 1)
- AF_LEVEL, DEPTH-2, almost_full asserts when occupancy ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when occupancy ≤ AE_LEVEL (0..DEPTH-1)
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- push_valid  input  1  producer has a word
- push_ready  output  1  FIFO accepts a word
- push_payload  input  DATA_WIDTH  word to enqueue
- pop_valid  output  1  head word available
- pop_ready  input  1  consumer takes the word
- pop_payload  output  DATA_WIDTH  head word
- flush  input  1  synchronous empty request
- occupancy  output  DEPTH_LOG2+1  stored words, 0..DEPTH
- availability  output  DEPTH_LOG2+1  DEPTH − occupancy
- almost_full  output  1  occupancy ≥ AF_LEVEL
- almost_empty  output  1  occupancy ≤ AE_LEVEL
- wm_clear  input  1  watermark reload (macro-dependent)
- wm_peak  output  DEPTH_LOG2+1  peak occupancy (macro-dependent)

## Operation
- Storage: DEPTH × DATA_WIDTH RAM, synchronous write at push_ptr, synchronous read at pop_ptr_next; pop_payload is the RAM read register.
- Pointers push_ptr/pop_ptr are DEPTH_LOG2 bits and wrap modulo DEPTH naturally. A rising flag disambiguates full from empty on pointer match.
- pushing = push_valid & push_ready; popping = pop_valid & pop_ready.
- push_ready = !full; empty = match & !rising; full = match & rising.
- rising ← pushing when pushing ≠ popping; it is unchanged otherwise.
- occupancy = {full, push_ptr − pop_ptr} (width DEPTH_LOG2+1).
- Read-hazard register hz ← (pop_ptr_next == push_ptr) each edge. pop_valid = !empty & !(hz & !full). This masks a RAM read that collided with the same-edge write.
- Simultaneous push and pop when not empty and not full: both complete, occupancy unchanged.
- When full: push_ready = 0. A pop frees one slot, and push_ready rises in the following cycle; there is no same-cycle pass-through.
- When empty: pop_valid = 0, and pop_ready is ignored.
- flush = 1 at an edge: both pointers ← 0 and rising ← 0, overriding push and pop.
  - A handshake in the flush cycle still completes on the bus.
  - A pushed word in the flush cycle is discarded.
- almost_full and almost_empty are combinational from occupancy.

## Timing
- Reset values: push_ready = 1, pop_valid = 0, occupancy = 0, availability = DEPTH, almost_full = 0, almost_empty = 1, wm_peak = 0, hz = 0, pop_payload undefined.
- Reset asserted mid-operation empties the FIFO immediately (asynchronously). RAM contents are not cleared.
- Push accepted into an empty FIFO at edge E:
  - occupancy = 1 after E.
  - pop_valid = 1 after E+1 (one masked cycle).
  - Minimum first-word latency is 2 cycles.
- Back-to-back: a non-empty FIFO sustains one pop per cycle together with one push per cycle.
- After a pop, the next head word is valid in the next cycle (read address is pop_ptr_next).
- Flush at edge F: occupancy = 0 and pop_valid = 0 after F.

## Configuration
- STREAM_FIFO_WATERMARK_EN defined:
  - wm_peak register: wm_peak ← max(wm_peak, occupancy) each edge.
  - wm_clear = 1 loads wm_peak ← occupancy, with priority over the max update.
  - flush does not clear wm_peak; reset sets it to 0.
- Not defined: no watermark register, wm_peak is tied to 0 and wm_clear is ignored.

## Test plan
- Reset, then 1 push of 0xA5 at cycle 0 (DATA_WIDTH=8, DEPTH_LOG2=4):
  - occupancy = 1 at cycle 1, pop_valid = 1 at cycle 2, pop_payload = 0xA5.
  - Pop, then occupancy = 0 and almost_empty = 1.
- Fill with 16 pushes 0x00..0x0F, pop_ready = 0: push_ready = 0, occupancy = 16, availability = 0, almost_full = 1. One pop returns 0x00, and push_ready = 1 in the next cycle.
- Continuous push and pop for 40 words with both pointers wrapping: output order exactly equals input order, no drops or duplicates, occupancy constant during steady state.
- Occupancy = 5, flush = 1 with simultaneous push of 0x77: after the edge occupancy = 0 and pop_valid = 0; 0x77 never appears at pop.
- Reset asserted with occupancy = 9: all outputs take their reset values in the same cycle, before the next clk edge.
- STREAM_FIFO_WATERMARK_EN:
  - Push 12, pop 12: wm_peak = 12.
  - wm_clear with occupancy 0: wm_peak = 0.
  - Without the macro, wm_peak stays 0 throughout.
